mem_wb_stage: RTL

//  Memory stage plus MEM/WB pipeline register of the 8-bit pipelined core.

---
 rtl/mem_wb_stage_pkg.sv | 28 ++
 rtl/mem_wb_stage_data_memory.sv | 31 +++
 rtl/mem_wb_stage_register.sv | 20 ++
 rtl/mem_wb_stage.sv | 74 +++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared constants, write-back select encodings and the MEM/WB bundle layout
// for the memory / write-back stage of the 8-bit core.
package mem_wb_stage_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DEST_W    = 3;
  localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] memData;
    logic [DATA_W-1:0] aluResult;
    logic [DEST_W-1:0] dest;
    logic              regWrite;
    logic              sel;
  } wbBundle_t;

  localparam int unsigned WB_BUNDLE_W = $bits(wbBundle_t);

  // Memory address from the ALU result: truncate or zero-extend to ADDR_W.
  function automatic logic [ADDR_W-1:0] toAddr(input logic [DATA_W-1:0] value);
    return ADDR_W'(value);
  endfunction

endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// Data memory: asynchronous read, synchronous write, asynchronous clear of
// every word on active-low reset.
module data_memory
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned AW    = ADDR_W,
  parameter int unsigned DEPTH = 1 << AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             writeEn,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] writeData,
  output logic [WIDTH-1:0] readData
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read sees the pre-edge contents, so a same-cycle store is not visible.
  assign readData = mem[addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '{default: '0};
    end else if (writeEn) begin
      mem[addr] <= writeData;
    end
  end

endmodule

// File: rtl/mem_wb_stage_register.sv
// Generic load-enabled register with asynchronous active-low clear.
module register #(
  parameter int unsigned SIZE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB pipeline register: data-memory access, MEM-stage
// forward value, and the registered write-back bundle for the register file.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [DATA_W-1:0] IaluResult,
  input  logic [DATA_W-1:0] Ir2,
  input  logic [DEST_W-1:0] Idest,
  input  logic              IDMMemWrite,
  input  logic              IregWrite,
  input  logic              IregWriteDataSel,
  output logic [DATA_W-1:0] memFwdData,
  output logic [DEST_W-1:0] memFwdDest,
  output logic              memFwdValid,
  output logic [DATA_W-1:0] wbData,
  output logic [DEST_W-1:0] wbDest,
  output logic              wbRegWrite
);

  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] rdData;
  logic              memWriteEn;
  wbBundle_t         wbNext;
  wbBundle_t         wbReg;

  assign memAddr    = toAddr(IaluResult);
  assign memWriteEn = IDMMemWrite && !stall;

  data_memory #(
    .WIDTH (DATA_W),
    .AW    (ADDR_W),
    .DEPTH (MEM_DEPTH)
  ) uDataMemory (
    .clk       (clk),
    .rst       (rst),
    .writeEn   (memWriteEn),
    .addr      (memAddr),
    .writeData (Ir2),
    .readData  (rdData)
  );

  // Forwarding path sees the loaded value in the same cycle.
  assign memFwdData  = (IregWriteDataSel == WB_SEL_MEM) ? rdData : IaluResult;
  assign memFwdDest  = Idest;
  assign memFwdValid = IregWrite;

  always_comb begin
    wbNext           = '0;
    wbNext.memData   = rdData;
    wbNext.aluResult = IaluResult;
    wbNext.dest      = Idest;
    wbNext.regWrite  = IregWrite;
    wbNext.sel       = IregWriteDataSel;
  end

  register #(
    .SIZE (WB_BUNDLE_W)
  ) uMemWbReg (
    .clk  (clk),
    .rst  (rst),
    .load (!stall),
    .d    (wbNext),
    .q    (wbReg)
  );

  // Write-back selection uses only registered fields.
  assign wbData     = (wbReg.sel == WB_SEL_MEM) ? wbReg.memData : wbReg.aluResult;
  assign wbDest     = wbReg.dest;
  assign wbRegWrite = wbReg.regWrite;

endmodule
